// File: rtl/pipelined_control_unit.sv
// Decode stage and ID/EX control register for the RV32I/RV32E pipeline.
// Handles the fetch handshake, load-use stall bubbles, redirect flush and illegal flagging.
module pipelined_control_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  write_o,
    output logic                  store_o,
    output logic                  load_o,
    output logic                  branch_o,
    output logic [1:0]            alu_a_sel_o,
    output logic                  alu_b_sel_o,
    output logic [1:0]            imm_sel_o,
    output logic [1:0]            next_pc_sel_o,
    output logic [3:0]            alu_op_o,
    output logic [2:0]            funct3_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd15;

    // Counter holds the stalled edges still owed after the one that detected the hazard.
    localparam logic [1:0] STALL_INIT = 2'(LOAD_LATENCY - 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  write;
        logic                  store;
        logic                  load;
        logic                  branch;
        logic [1:0]            a_sel;
        logic                  b_sel;
        logic [1:0]            imm_sel;
        logic [1:0]            npc_sel;
        logic [3:0]            alu_op;
        logic [2:0]            funct3;
        logic                  illegal;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      bundle_q;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       known_op;
    logic       rv32e_bad;
    logic       hazard;
    logic       accept;
    logic [1:0] stall_cnt;
    logic       unused_instr;

    assign unused_instr = ^{instr_i[31], instr_i[29:25]};

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                   input logic sub_ok);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        known_op   = 1'b1;
        dec.rs1    = instr_i[15 +: REG_ADDR_W];
        dec.rs2    = instr_i[20 +: REG_ADDR_W];
        dec.rd     = instr_i[7 +: REG_ADDR_W];
        dec.funct3 = instr_i[14:12];
        case (instr_i[6:0])
            OP_R: begin
                dec.write  = 1'b1;
                dec.alu_op = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b1);
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                use_rd     = 1'b1;
            end
            OP_IMM: begin
                dec.write  = 1'b1;
                dec.b_sel  = 1'b1;
                dec.alu_op = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b0);
                use_rs1    = 1'b1;
                use_rd     = 1'b1;
            end
            OP_LOAD: begin
                dec.write = 1'b1;
                dec.load  = 1'b1;
                dec.b_sel = 1'b1;
                use_rs1   = 1'b1;
                use_rd    = 1'b1;
            end
            OP_STORE: begin
                dec.store   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.imm_sel = 2'd1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_sel = 2'd3;
                dec.npc_sel = 2'd2;
                dec.alu_op  = ALU_SUB;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_JAL: begin
                dec.write   = 1'b1;
                dec.a_sel   = 2'd1;
                dec.imm_sel = 2'd3;
                dec.npc_sel = 2'd3;
                use_rd      = 1'b1;
            end
            OP_JALR: begin
                dec.write   = 1'b1;
                dec.a_sel   = 2'd1;
                dec.npc_sel = 2'd1;
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
            end
            OP_LUI: begin
                dec.write   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.imm_sel = 2'd2;
                dec.alu_op  = ALU_PASS_B;
                use_rd      = 1'b1;
            end
            OP_AUIPC: begin
                dec.write   = 1'b1;
                dec.a_sel   = 2'd2;
                dec.b_sel   = 1'b1;
                dec.imm_sel = 2'd2;
                use_rd      = 1'b1;
            end
            default: known_op = 1'b0;
        endcase
        // RV32E only has x0..x15: the top bit of any register field the format uses must be clear.
        rv32e_bad = (REG_ADDR_W < 5) &&
                    ((use_rd && instr_i[11]) || (use_rs1 && instr_i[19]) || (use_rs2 && instr_i[24]));
        if (!known_op || rv32e_bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    assign hazard = in_valid_i && out_valid_o && bundle_q.load && (bundle_q.rd != '0) &&
                    (stall_cnt == '0) &&
                    ((use_rs1 && (dec.rs1 == bundle_q.rd)) || (use_rs2 && (dec.rs2 == bundle_q.rd)));

    assign in_ready_o = rst_n && !hazard && (stall_cnt == '0) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush_i) begin
            stall_cnt <= '0;
        end else if (hazard) begin
            stall_cnt <= STALL_INIT;
        end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            out_valid_o <= 1'b0;
        end else if (accept) begin
            bundle_q    <= dec;
            out_valid_o <= 1'b1;
        end else begin
            bundle_q    <= '0;
            out_valid_o <= 1'b0;
        end
    end

    assign rs1_o         = bundle_q.rs1;
    assign rs2_o         = bundle_q.rs2;
    assign rd_o          = bundle_q.rd;
    assign write_o       = bundle_q.write;
    assign store_o       = bundle_q.store;
    assign load_o        = bundle_q.load;
    assign branch_o      = bundle_q.branch;
    assign alu_a_sel_o   = bundle_q.a_sel;
    assign alu_b_sel_o   = bundle_q.b_sel;
    assign imm_sel_o     = bundle_q.imm_sel;
    assign next_pc_sel_o = bundle_q.npc_sel;
    assign alu_op_o      = bundle_q.alu_op;
    assign funct3_o      = bundle_q.funct3;
    assign illegal_o     = bundle_q.illegal;

endmodule
